ds_reg_commit_scheduler: RTL and testbench

- Controller that sequences the delta-sigma modulator's sample updates and owns its parameter registers.
- Accepts byte-wide host writes into shadow registers.
- Generates the modulator step strobe at a programmable period.
- Commits dirty shadow registers to the active register bank exactly at step boundaries, so the modulator never sees a half-written 16-bit value. Also drives the pulse_toggle marker used for pulse-width measurement.

---
 rtl/ds_reg_commit_scheduler_if.sv | 15 +
 rtl/ds_reg_commit_scheduler.sv | 92 +++++++++
 tb/tb_ds_reg_commit_scheduler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ds_reg_commit_scheduler_if.sv
// Host byte-write bus for the delta-sigma register/commit scheduler.
//   wr_en   : byte write strobe, one write per asserted cycle
//   wr_addr : {reg index[3:1], byte sel[0]}, bit0=1 selects the high byte
//   wr_data : byte to write
//   wr_err  : one-cycle pulse returned for an out-of-range write
// master = host side, slave = scheduler side.
interface ds_reg_commit_scheduler_if;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_err;

  modport master (output wr_en, output wr_addr, output wr_data, input wr_err);
  modport slave  (input wr_en, input wr_addr, input wr_data, output wr_err);
endinterface

// File: rtl/ds_reg_commit_scheduler.sv
// Step scheduler and parameter register bank for the delta-sigma modulator.
// Host byte writes land in shadow registers; a high-byte write marks the
// register dirty. Dirty shadows are copied to the active bank on the same
// edge that raises the step strobe, so the modulator never sees a
// half-written 16-bit value.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   enable         : run the step divider
//   period         : step interval minus one, in clk cycles
//   bus            : host byte-write interface (slave side)
//   regs_out       : active registers, reg i at [16i+15:16i]
//   step           : one-cycle modulator step strobe
//   pulse_toggle   : flips on every step
//   commit_pending : OR of all dirty flags
module ds_reg_commit_scheduler #(
  parameter int unsigned NUM_REGS    = 3,
  parameter int unsigned REG_BITS    = 16,
  parameter int unsigned PERIOD_BITS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [PERIOD_BITS-1:0]     period,
  ds_reg_commit_scheduler_if.slave   bus,
  output logic [NUM_REGS*16-1:0]     regs_out,
  output logic                       step,
  output logic                       pulse_toggle,
  output logic                       commit_pending
);

  logic [PERIOD_BITS-1:0] cnt;
  logic [15:0]            shadow [NUM_REGS];
  logic [NUM_REGS-1:0]    dirty;
  logic [NUM_REGS-1:0]    dirty_next;
  logic                   fire;
  logic [2:0]             wr_idx;
  logic                   wr_in_range;
  logic                   wr_ok;

  always_comb begin
    fire        = enable && (cnt == '0);
    wr_idx      = bus.wr_addr[3:1];
    wr_in_range = (32'(wr_idx) < NUM_REGS);
    wr_ok       = bus.wr_en && wr_in_range;
    // Commit clears first, then a coincident high-byte write re-marks dirty
    // so the newly written value goes out on the following step.
    dirty_next = dirty;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (fire) dirty_next[i] = 1'b0;
      if (wr_ok && bus.wr_addr[0] && (32'(wr_idx) == i)) dirty_next[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt            <= '0;
      step           <= 1'b0;
      pulse_toggle   <= 1'b0;
      regs_out       <= '0;
      dirty          <= '0;
      commit_pending <= 1'b0;
      bus.wr_err     <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
    end else begin
      if (!enable) begin
        cnt  <= period;
        step <= 1'b0;
      end else if (fire) begin
        cnt          <= period;
        step         <= 1'b1;
        pulse_toggle <= ~pulse_toggle;
      end else begin
        cnt  <= cnt - 1'b1;
        step <= 1'b0;
      end

      // Commit reads the pre-write shadow; a same-edge write is not visible.
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (fire && dirty[i]) regs_out[16*i +: 16] <= shadow[i];
        if (wr_ok && (32'(wr_idx) == i)) begin
          if (bus.wr_addr[0]) shadow[i][15:8] <= bus.wr_data;
          else                shadow[i][7:0]  <= bus.wr_data;
        end
      end

      dirty          <= dirty_next;
      commit_pending <= |dirty_next;
      bus.wr_err     <= bus.wr_en && !wr_in_range;
    end
  end

endmodule

// File: tb/tb_ds_reg_commit_scheduler.sv
module tb_ds_reg_commit_scheduler;
  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] period;
  logic [47:0] regs_out;
  logic       step;
  logic       pulse_toggle;
  logic       commit_pending;

  int unsigned total = 0;
  int unsigned bad   = 0;

  ds_reg_commit_scheduler_if bus ();

  ds_reg_commit_scheduler #(.NUM_REGS(3), .REG_BITS(16), .PERIOD_BITS(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .period         (period),
    .bus            (bus.slave),
    .regs_out       (regs_out),
    .step           (step),
    .pulse_toggle   (pulse_toggle),
    .commit_pending (commit_pending)
  );

  always #5 clk = ~clk;

  // Reference model: a step is due when the wait counter runs out; pending
  // values are held per register and published on each step.
  int m_wait;
  bit m_step, m_tog, m_err, m_pend;
  int m_shadow [3];
  bit m_dirty  [3];
  int m_active [3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit due;
    int idx;
    if (reset) begin
      m_wait = 0; m_step = 0; m_tog = 0; m_err = 0; m_pend = 0;
      for (int i = 0; i < 3; i++) begin
        m_shadow[i] = 0; m_dirty[i] = 0; m_active[i] = 0;
      end
      return;
    end
    due = enable && (m_wait == 0);
    for (int i = 0; i < 3; i++)
      if (due && m_dirty[i]) begin
        m_active[i] = m_shadow[i];
        m_dirty[i]  = 0;
      end
    if (!enable || due) m_wait = period;
    else                m_wait = m_wait - 1;
    m_step = due;
    if (due) m_tog = !m_tog;
    m_err = 0;
    if (bus.wr_en) begin
      idx = int'(bus.wr_addr) / 2;
      if (idx < 3) begin
        if (bus.wr_addr % 2 == 1) begin
          m_shadow[idx] = (m_shadow[idx] % 256) + int'(bus.wr_data) * 256;
          m_dirty[idx]  = 1;
        end else begin
          m_shadow[idx] = (m_shadow[idx] / 256) * 256 + int'(bus.wr_data);
        end
      end else begin
        m_err = 1;
      end
    end
    m_pend = m_dirty[0] || m_dirty[1] || m_dirty[2];
  endtask

  task automatic tick();
    logic [47:0] exp_regs;
    model_edge();
    @(posedge clk);
    #1;
    exp_regs = {m_active[2][15:0], m_active[1][15:0], m_active[0][15:0]};
    check("step",           64'(step),           64'(m_step));
    check("pulse_toggle",   64'(pulse_toggle),   64'(m_tog));
    check("regs_out",       64'(regs_out),       64'(exp_regs));
    check("commit_pending", 64'(commit_pending), 64'(m_pend));
    check("wr_err",         64'(bus.wr_err),     64'(m_err));
  endtask

  task automatic wr(input logic [3:0] addr, input logic [7:0] data);
    bus.wr_en = 1'b1; bus.wr_addr = addr; bus.wr_data = data;
    tick();
    bus.wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; period = 8'd3;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    #1;
    // reset then free-running at period 3
    tick();
    reset = 1'b0;
    repeat (12) tick();
    // stage 0xBEEF into reg1 while idle, then start at period 5
    enable = 1'b0;
    tick();
    wr(4'd2, 8'hEF);
    wr(4'd3, 8'hBE);
    repeat (3) tick();
    check("beef_not_yet", 64'(regs_out[31:16]), 64'h0);
    enable = 1'b1; period = 8'd5;
    repeat (8) tick();
    check("beef_committed", 64'(regs_out[31:16]), 64'hBEEF);
    // low byte alone never commits; high byte does
    wr(4'd0, 8'h12);
    repeat (14) tick();
    wr(4'd1, 8'h34);
    repeat (7) tick();
    check("reg0_3412", 64'(regs_out[15:0]), 64'h3412);
    // period 0: writes coincide with step edges
    period = 8'd0;
    repeat (2) tick();
    wr(4'd5, 8'h55);
    wr(4'd5, 8'h55);
    wr(4'd4, 8'h66);
    repeat (2) tick();
    // out-of-range writes
    wr(4'd6, 8'hAA);
    wr(4'd7, 8'hBB);
    repeat (2) tick();
    // reset mid-count with a pending value
    enable = 1'b1; period = 8'd7;
    wr(4'd3, 8'h11);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("reset_regs", 64'(regs_out), 64'h0);
    reset = 1'b0;
    repeat (20) tick();
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset  = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) period = 8'($urandom_range(0, 6));
      bus.wr_en   = ($urandom_range(0, 2) == 0);
      bus.wr_addr = 4'($urandom_range(0, 7));
      bus.wr_data = 8'($urandom);
      tick();
    end
    reset = 1'b0; bus.wr_en = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
